// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline mode controller: config/flush state
// machines and the bit layout of the status LED bank.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CFG_START  = 2'd0,
    CFG_WAIT   = 2'd1,
    CFG_ACTIVE = 2'd2,
    CFG_ERROR  = 2'd3
  } cfg_state_e;

  typedef enum logic {
    FL_IDLE = 1'b0,
    FL_PEND = 1'b1
  } flush_state_e;

  localparam int LED_ACTIVE = 0;
  localparam int LED_CFG    = 1;
  localparam int LED_ERR    = 2;
  localparam int LED_FLUSH  = 3;
  localparam int LED_EN_LO  = 4;

endpackage

// File: rtl/pipe_mode_ctrl_debounce.sv
// Debouncer for one asynchronous board input: two-flop synchroniser, then the
// output follows only after the input has held a new level for DB_COUNT cycles.
module pipe_mode_ctrl_debounce #(
  parameter int DB_COUNT = 2500000
) (
  input  logic i_sysclk,
  input  logic i_rstn,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  logic          meta_q, sync_q, stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      // Any bounce back to the stable level restarts the qualification window.
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_COUNT - 1)) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/pipe_mode_ctrl.sv
// Board-to-pipeline controller: camera config sequencing with timeout/retry,
// debounced filter switches applied only at start-of-frame behind a flush.
module pipe_mode_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_FILTERS = 4,
  parameter int DB_COUNT    = 2500000,
  parameter int CFG_TIMEOUT = 12500000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                   i_sysclk,
  input  logic                   i_rstn,
  input  logic                   i_sof,
  input  logic                   i_cfg_done,
  input  logic [NUM_FILTERS-1:0] i_sw,
  input  logic                   i_btn_recfg,
  output logic                   o_cfg_start,
  output logic                   o_cfg_err,
  output logic                   o_pipe_flush,
  output logic [NUM_FILTERS-1:0] o_filter_en,
  output logic [7:0]             o_status_leds
);

  localparam int NW = NUM_FILTERS + 1;
  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int LN = (NUM_FILTERS < 4) ? NUM_FILTERS : 4;

  logic [NW-1:0] raw, db, sync1_q, sync2_q;
  logic [NUM_FILTERS-1:0] sw_stable, sw_delta;
  logic btn_rise;

  cfg_state_e   cfg_q, cfg_d;
  flush_state_e fl_q, fl_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rty_q, rty_d;
  logic [NUM_FILTERS-1:0] en_q, en_d;
  logic cfg_start_q, cfg_err_q, flush_q, flush_d;
  logic [7:0] leds_q, leds_d;
  logic [3:0] led_en;

  assign raw = {i_btn_recfg, i_sw};

  genvar g;
  generate
    for (g = 0; g < NW; g++) begin : g_db
      pipe_mode_ctrl_debounce #(.DB_COUNT(DB_COUNT)) u_db (
        .i_sysclk (i_sysclk),
        .i_rstn   (i_rstn),
        .raw_i    (raw[g]),
        .stable_o (db[g])
      );
    end
  endgenerate

  assign sw_stable = sync2_q[NUM_FILTERS-1:0];
  assign sw_delta  = sync1_q[NUM_FILTERS-1:0] ^ sync2_q[NUM_FILTERS-1:0];
  assign btn_rise  = sync1_q[NUM_FILTERS] & ~sync2_q[NUM_FILTERS];

  always_comb begin
    cfg_d = cfg_q;
    tmo_d = tmo_q;
    rty_d = rty_q;
    unique case (cfg_q)
      CFG_START: begin
        tmo_d = '0;
        cfg_d = CFG_WAIT;
      end
      CFG_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // Done wins over a timeout landing in the same cycle.
        if (i_cfg_done) begin
          cfg_d = CFG_ACTIVE;
          rty_d = '0;
        end else if (tmo_q == TW'(CFG_TIMEOUT - 1)) begin
          if (rty_q < RW'(MAX_RETRY)) begin
            rty_d = rty_q + RW'(1);
            cfg_d = CFG_START;
          end else begin
            cfg_d = CFG_ERROR;
          end
        end
      end
      CFG_ACTIVE, CFG_ERROR: begin
        if (btn_rise) begin
          cfg_d = CFG_START;
          rty_d = '0;
        end
      end
      default: cfg_d = CFG_START;
    endcase
  end

  always_comb begin
    fl_d = fl_q;
    en_d = en_q;
    unique case (fl_q)
      FL_IDLE: begin
        // Changes seen while unconfigured are caught up on entry to ACTIVE.
        if (cfg_q == CFG_ACTIVE && sw_delta != '0) begin
          fl_d = FL_PEND;
        end else if (cfg_q != CFG_ACTIVE && cfg_d == CFG_ACTIVE &&
                     (sw_stable != en_q || sw_delta != '0)) begin
          fl_d = FL_PEND;
        end
      end
      FL_PEND: begin
        if (i_sof && sw_delta == '0) begin
          en_d = sw_stable;
          fl_d = FL_IDLE;
        end
      end
      default: fl_d = FL_IDLE;
    endcase
  end

  always_comb begin
    led_en         = '0;
    led_en[LN-1:0] = en_d[LN-1:0];
    flush_d        = (cfg_q != CFG_ACTIVE) || (fl_q == FL_PEND);
    leds_d                 = '0;
    leds_d[LED_ACTIVE]     = (cfg_q == CFG_ACTIVE);
    leds_d[LED_CFG]        = (cfg_q == CFG_START) || (cfg_q == CFG_WAIT);
    leds_d[LED_ERR]        = (cfg_q == CFG_ERROR);
    leds_d[LED_FLUSH]      = flush_d;
    leds_d[LED_EN_LO +: 4] = led_en;
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cfg_q       <= CFG_START;
      fl_q        <= FL_IDLE;
      tmo_q       <= '0;
      rty_q       <= '0;
      en_q        <= '0;
      cfg_start_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      flush_q     <= 1'b1;
      leds_q      <= '0;
    end else begin
      sync1_q     <= db;
      sync2_q     <= sync1_q;
      cfg_q       <= cfg_d;
      fl_q        <= fl_d;
      tmo_q       <= tmo_d;
      rty_q       <= rty_d;
      en_q        <= en_d;
      cfg_start_q <= (cfg_q == CFG_START);
      cfg_err_q   <= (cfg_q == CFG_ERROR);
      flush_q     <= flush_d;
      leds_q      <= leds_d;
    end
  end

  assign o_cfg_start   = cfg_start_q;
  assign o_cfg_err     = cfg_err_q;
  assign o_pipe_flush  = flush_q;
  assign o_filter_en   = en_q;
  assign o_status_leds = leds_q;

endmodule

// File: tb/tb_pipe_mode_ctrl.sv
// Directed bench for pipe_mode_ctrl with short debounce/timeout settings.
module tb_pipe_mode_ctrl;

  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rstn, sof, done, btn;
  logic [NF-1:0] sw;
  logic          cfg_start, cfg_err, flush;
  logic [NF-1:0] en;
  logic [7:0]    leds;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_start_cyc = 0;
  int n0, c1, c2;

  pipe_mode_ctrl #(
    .NUM_FILTERS(NF), .DB_COUNT(2), .CFG_TIMEOUT(8), .MAX_RETRY(1)
  ) dut (
    .i_sysclk      (clk),
    .i_rstn        (rstn),
    .i_sof         (sof),
    .i_cfg_done    (done),
    .i_sw          (sw),
    .i_btn_recfg   (btn),
    .o_cfg_start   (cfg_start),
    .o_cfg_err     (cfg_err),
    .o_pipe_flush  (flush),
    .o_filter_en   (en),
    .o_status_leds (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (cfg_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag, input int bound);
    int n = start_cnt;
    int i = 0;
    while (start_cnt == n && i < bound) begin
      step();
      i++;
    end
    chk(tag, 32'(start_cnt != n), 32'd1);
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (6) step();
    btn = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sof = 1'b0; done = 1'b0; btn = 1'b0; sw = '0;
    repeat (3) step();
    chk("rst_start", 32'(cfg_start), 32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_flush", 32'(flush),     32'd1);
    chk("rst_en",    32'(en),        32'd0);
    chk("rst_leds",  32'(leds),      32'd0);

    // Normal configuration, done 3 cycles after the start pulse
    rstn = 1'b1;
    step();
    chk("t1_start_pulse", 32'(cfg_start), 32'd1);
    repeat (3) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t1_flush_on_entry", 32'(flush), 32'd1);
    step();
    chk("t1_flush_drop", 32'(flush), 32'd0);
    chk("t1_leds", 32'(leds), 32'h01);
    chk("t1_one_start", 32'(start_cnt), 32'd1);

    // Switch change applied at SOF
    sw = 4'b0101;
    repeat (10) step();
    chk("t3_pend_flush", 32'(flush), 32'd1);
    chk("t3_en_held", 32'(en), 32'd0);
    sof = 1'b1;
    step();
    sof = 1'b0;
    chk("t3_en_applied", 32'(en), 32'h5);
    chk("t3_leds_en", 32'(leds[7:4]), 32'h5);
    step();
    chk("t3_flush_clear", 32'(flush), 32'd0);
    chk("t3_leds", 32'(leds), 32'h51);

    // Delta coinciding with SOF defers the update
    sw = 4'b0111;
    repeat (8) step();
    chk("t4_pend", 32'(flush), 32'd1);
    sw = 4'b0011;
    repeat (5) step();
    sof = 1'b1;
    step();
    sof = 1'b0;
    chk("t4_en_kept", 32'(en), 32'h5);
    chk("t4_flush_kept", 32'(flush), 32'd1);
    repeat (3) step();
    sof = 1'b1;
    step();
    sof = 1'b0;
    chk("t4_en_applied", 32'(en), 32'h3);
    step();
    chk("t4_leds", 32'(leds), 32'h31);

    // Timeout, retry and error
    n0 = start_cnt;
    press_btn();
    wait_start("t2_first_start", 20);
    c1 = last_start_cyc;
    wait_start("t2_retry_start", 20);
    c2 = last_start_cyc;
    chk("t2_spacing", 32'(c2 - c1), 32'd9);
    repeat (8) step();
    chk("t2_err_not_yet", 32'(cfg_err), 32'd0);
    step();
    chk("t2_err", 32'(cfg_err), 32'd1);
    chk("t2_leds", 32'(leds), 32'h3C);
    chk("t2_two_starts", 32'(start_cnt - n0), 32'd2);
    press_btn();
    wait_start("t2_recover_start", 20);
    chk("t2_err_clear", 32'(cfg_err), 32'd0);
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    chk("t2_active_flush", 32'(flush), 32'd0);
    chk("t2_active_leds", 32'(leds), 32'h31);

    // Reset while a flush is pending
    sw = 4'b1000;
    repeat (7) step();
    chk("t5_pend", 32'(flush), 32'd1);
    rstn = 1'b0;
    step();
    chk("t5_en", 32'(en), 32'd0);
    chk("t5_flush", 32'(flush), 32'd1);
    chk("t5_start_low", 32'(cfg_start), 32'd0);
    chk("t5_leds", 32'(leds), 32'd0);
    rstn = 1'b1;
    n0 = start_cnt;
    step();
    chk("t5_restart", 32'(cfg_start), 32'd1);

    // Button and switch activity during CFG_WAIT
    btn = 1'b1;
    sw  = 4'b1001;
    repeat (5) step();
    btn = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (3) step();
    chk("t6_flush_pend", 32'(flush), 32'd1);
    chk("t6_en_held", 32'(en), 32'd0);
    chk("t6_no_extra_start", 32'(start_cnt - n0), 32'd1);
    sof = 1'b1;
    step();
    sof = 1'b0;
    chk("t6_en_applied", 32'(en), 32'h9);
    step();
    chk("t6_flush_clear", 32'(flush), 32'd0);
    chk("t6_leds", 32'(leds), 32'h91);
    repeat (4) step();
    chk("t6_flush_stays", 32'(flush), 32'd0);
    chk("t6_final_starts", 32'(start_cnt - n0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
